// File: rtl/ts5n65lpa_32x128_m2_if.sv
// Access bus of the 32x128 single-port SRAM macro: control, address, data,
// per-bit write mask and registered read data.
interface ts5n65lpa_32x128_m2_if #(
  parameter int BITS = 128,
  parameter int AW   = 5
);
  logic            CEB;
  logic            WEB;
  logic [AW-1:0]   A;
  logic [BITS-1:0] D;
  logic [BITS-1:0] BWEB;
  logic [BITS-1:0] Q;

  modport master (output CEB, WEB, A, D, BWEB, input Q);
  modport slave  (input CEB, WEB, A, D, BWEB, output Q);
endinterface

// File: rtl/ts5n65lpa_32x128_m2.sv
// Single-port synchronous SRAM model: one access per cycle, bit-masked
// writes with write-through onto Q, 1-cycle registered read data.
module ts5n65lpa_32x128_m2 #(
  parameter int WORDS = 32,
  parameter int BITS  = 128,
  parameter int AW    = 5
) (
  input  logic CLK,
  input  logic RESET,
  ts5n65lpa_32x128_m2_if.slave bus
);

  logic [BITS-1:0] mem [WORDS];
  logic            in_range;
  logic [BITS-1:0] rd_word;
  logic [BITS-1:0] wr_word;
  logic            do_wr;

  always_comb begin
    in_range = int'(bus.A) < WORDS;
    rd_word  = in_range ? mem[bus.A] : '0;
    // BWEB bit low selects the new data bit, high keeps the stored bit
    wr_word  = (rd_word & bus.BWEB) | (bus.D & ~bus.BWEB);
    do_wr    = !RESET && !bus.CEB && !bus.WEB && in_range;
  end

  // The array has no reset so its contents survive RESET
  always_ff @(posedge CLK) begin
    if (do_wr) mem[bus.A] <= wr_word;
  end

  always_ff @(posedge CLK) begin
    if (RESET)
      bus.Q <= '0;
    else if (!bus.CEB) begin
      if (!in_range)    bus.Q <= '0;
      else if (bus.WEB) bus.Q <= rd_word;
      else              bus.Q <= wr_word;
    end
  end

`ifndef SYNTHESIS
  always @(posedge CLK) begin
    if (bus.CEB == 1'b0)
      assert (!$isunknown({bus.A, bus.WEB, bus.BWEB}))
        else $error("ts5n65lpa_32x128_m2: unknown A/WEB/BWEB while CEB=0");
    assert (AW >= $clog2(WORDS))
      else $error("ts5n65lpa_32x128_m2: AW too narrow for WORDS");
  end
`endif

endmodule

// File: tb/tb_ts5n65lpa_32x128_m2.sv
// Scoreboard bench: stimulus pushes expected Q per edge, a negedge monitor
// pops and compares only the bits the reference model knows.
module tb_ts5n65lpa_32x128_m2;
  localparam int WORDS = 32;
  localparam int BITS  = 128;
  localparam int AW    = 5;

  typedef struct {
    logic [BITS-1:0] exp;
    logic [BITS-1:0] known;
    string           tag;
  } exp_t;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  ts5n65lpa_32x128_m2_if #(.BITS(BITS), .AW(AW)) bus ();

  ts5n65lpa_32x128_m2 #(.WORDS(WORDS), .BITS(BITS), .AW(AW)) dut (
    .CLK(CLK), .RESET(RESET), .bus(bus)
  );

  exp_t            sb[$];
  int              n_tests = 0;
  int              n_fail  = 0;
  logic [BITS-1:0] mem_m   [WORDS];
  logic [BITS-1:0] known_m [WORDS];
  logic [BITS-1:0] q_m;
  logic [BITS-1:0] q_k;

  // Monitor: one expectation per rising edge, checked on the falling edge
  initial begin
    forever begin
      @(negedge CLK);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        n_tests++;
        if (((bus.Q ^ e.exp) & e.known) !== '0) begin
          n_fail++;
          $display("FAIL %s: Q=%h expected %h (mask %h)", e.tag, bus.Q, e.exp, e.known);
        end
      end
    end
  end

  function automatic logic [BITS-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Drive one cycle (called at posedge+1), update the reference model,
  // then push what Q must be after the coming edge.
  task automatic step(input logic rst, input logic ceb, input logic web,
                      input int a, input logic [BITS-1:0] d,
                      input logic [BITS-1:0] bweb, input string tag);
    exp_t e;
    RESET    = rst;
    bus.CEB  = ceb;
    bus.WEB  = web;
    bus.A    = AW'(a);
    bus.D    = d;
    bus.BWEB = bweb;
    if (rst) begin
      q_m = '0;
      q_k = '1;
    end else if (!ceb) begin
      if (a >= WORDS) begin
        q_m = '0;
        q_k = '1;
      end else begin
        if (!web)
          for (int i = 0; i < BITS; i++)
            if (!bweb[i]) begin
              mem_m[a][i]   = d[i];
              known_m[a][i] = 1'b1;
            end
        q_m = mem_m[a];
        q_k = known_m[a];
      end
    end
    @(posedge CLK);
    e.exp = q_m; e.known = q_k; e.tag = tag;
    sb.push_back(e);
    #1;
  endtask

  task automatic wr(input int a, input logic [BITS-1:0] d,
                    input logic [BITS-1:0] bweb, input string tag);
    step(1'b0, 1'b0, 1'b0, a, d, bweb, tag);
  endtask

  task automatic rd(input int a, input string tag);
    step(1'b0, 1'b0, 1'b1, a, '0, '1, tag);
  endtask

  task automatic idle(input string tag);
    step(1'b0, 1'b1, 1'b1, 0, '0, '1, tag);
  endtask

  initial begin
    q_m = '0;
    q_k = '0;
    for (int i = 0; i < WORDS; i++) begin
      mem_m[i]   = '0;
      known_m[i] = '0;
    end
    RESET = 1'b1; bus.CEB = 1'b1; bus.WEB = 1'b1;
    bus.A = '0; bus.D = '0; bus.BWEB = '1;

    step(1'b1, 1'b1, 1'b1, 0, '0, '1, "reset_q0");
    repeat (3) idle("idle_after_reset");

    wr(5, {16{8'hA5}}, '0, "wr5_through");
    rd(5, "rd5_a5");

    wr(7, '1, '0, "wr7_ones");
    wr(7, '0, {{64{1'b1}}, {64{1'b0}}}, "wr7_masked_through");
    rd(7, "rd7_masked");

    wr(3, 128'h1234, '0, "wr3_1234");
    step(1'b1, 1'b0, 1'b0, 3, 128'hFFFF, '0, "reset_during_write_q0");
    rd(3, "rd3_no_write_on_reset");

    wr(3, '1, '1, "wr3_bweb_all_ones");
    rd(3, "rd3_unchanged");

    for (int a = 0; a < WORDS; a++) wr(a, {16{8'(a)}}, '0, "fill_through");
    for (int a = 0; a < WORDS; a++) rd(a, "b2b_read");
    rd(0, "wrap_read0");

    wr(9, 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555, '0, "wr9");
    rd(9, "rd9");
    idle("hold9_a");
    idle("hold9_b");
    step(1'b0, 1'b1, 1'b0, 9, '0, '0, "ceb_write_ignored_q");
    rd(9, "rd9_after_ceb_write");

    wr(12, rnd128(), '0, "wr12");
    rd(12, "raw_same_addr");

    for (int n = 0; n < 400; n++) begin
      int              a;
      logic [BITS-1:0] m;
      a = $urandom_range(WORDS - 1);
      case ($urandom_range(3))
        0: m = '0;
        1: m = '1;
        default: m = rnd128();
      endcase
      case ($urandom_range(9))
        0:       step(1'b1, $urandom_range(1), $urandom_range(1), a, rnd128(), m, "rnd_reset");
        1, 2:    idle("rnd_idle");
        3, 4, 5: wr(a, rnd128(), m, "rnd_write");
        default: rd(a, "rnd_read");
      endcase
    end

    for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge CLK);
    #1;
    if (sb.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
